// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS types, opcode constants and the IF/ID payload layout
package mips_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    SE_SIGN16 = 3'b000,
    SE_ZERO16 = 3'b001,
    SE_LUI    = 3'b010,
    SE_SIGN8  = 3'b011,
    SE_ZERO8  = 3'b100
  } se_select_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    se_select_t      se_select;
  } ifid_payload_t;
endpackage

// File: rtl/se_select_decode.sv
// se_select_decode: opcode -> extender mode (ports: opcode in, se_select out); only 16-bit modes are produced
module se_select_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output se_select_t se_select
);
  always_comb se_select = (opcode >= OP_ANDI && opcode <= OP_XORI) ? SE_ZERO16 :
                          (opcode == OP_LUI) ? SE_LUI : SE_SIGN16;
endmodule

// File: rtl/ifid_stage.sv
// ifid_stage: IF/ID register with 2-entry skid buffer and pre-decoded extender mode (ports: clk/rst, if_* fetch side, flush, id_* decode side)
module ifid_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc_plus4,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_pc_plus4,
  output logic [15:0]       id_imm,
  output logic [2:0]        id_se_select
);
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_instr, main_pc, skid_instr, skid_pc;
  se_select_t        main_se, skid_se, in_se;
  logic              accept, emit;
  se_select_decode u_dec (.opcode(if_instr[DATA_W-1:DATA_W-6]), .se_select(in_se));
  // if_ready depends only on the skid flop, so fetch never sees a path from id_ready
  assign if_ready     = ~rst & ~skid_valid;
  assign accept       = if_valid & if_ready;
  assign emit         = main_valid & id_ready;
  assign id_valid     = main_valid;
  assign id_instr     = main_instr;
  assign id_pc_plus4  = main_pc;
  assign id_imm       = main_instr[15:0];
  assign id_se_select = main_se;
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_instr <= NOP_INSTR;
      main_pc    <= '0;
      main_se    <= SE_SIGN16;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_se    <= SE_SIGN16;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_instr <= NOP_INSTR;
      main_se    <= SE_SIGN16;
    end else if (emit & skid_valid) begin
      main_instr <= skid_instr;
      main_pc    <= skid_pc;
      main_se    <= skid_se;
      skid_valid <= 1'b0;
    end else if (accept & (~main_valid | emit)) begin
      main_valid <= 1'b1;
      main_instr <= if_instr;
      main_pc    <= if_pc_plus4;
      main_se    <= in_se;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_instr <= if_instr;
      skid_pc    <= if_pc_plus4;
      skid_se    <= in_se;
    end else if (emit) begin
      main_valid <= 1'b0;
    end
  end
endmodule

// File: doc/ifid_stage.md
Name: ifid_stage

Overview:
- Registered IF/ID boundary of the MIPS datapath: captures the fetched instruction and PC+4 through a valid/ready handshake and presents them to decode.
- Pre-decodes the opcode into the 3-bit extender mode and the 16-bit immediate, so the sign-extension unit is fed directly from flops.
- Contains a 2-entry skid buffer (main + skid) so fetch-side ready is registered, giving full throughput under back-pressure.

Parameters:
- DATA_W, 32, instruction and PC width.
- NOP_INSTR, 32'h0000_0000, payload value for the instruction register on reset and flush.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- if_valid  input  1  fetch presents a beat.
- if_ready  output  1  stage can accept; asserted only when rst=0 and skid slot empty.
- if_instr  input  DATA_W  fetched instruction.
- if_pc_plus4  input  DATA_W  PC+4 of the fetched instruction.
- flush  input  1  branch/jump redirect; squashes all held beats.
- id_valid  output  1  decode-side beat valid.
- id_ready  input  1  decode accepts the beat.
- id_instr  output  DATA_W  held instruction.
- id_pc_plus4  output  DATA_W  held PC+4.
- id_imm  output  16  id_instr[15:0].
- id_se_select  output  3  extender mode for id_imm.

Behaviour:
- Reset (rst=1 at edge): main_valid=0, skid_valid=0, id_instr=NOP_INSTR, id_pc_plus4=0, id_imm=0, id_se_select=3'b000. if_ready=0 while rst=1.
- Accept: the beat transfers in when if_valid & if_ready. Emit: the beat transfers out when id_valid & id_ready.
- Latency: 1 cycle from accept to id_valid. Throughput: 1 beat/cycle when id_ready=1.
- Slot rules, per edge:
  - Main empty, or main emitting with skid empty: an accepted beat loads main.
  - Main full and not emitting: an accepted beat loads skid.
  - Main emitting with skid full: skid moves to main. An accepted beat in the same cycle is impossible, because if_ready=0.
- Ordering: beats leave in acceptance order. No drops or duplicates except on flush/reset.
- Hold: while id_valid & ~id_ready, all id_* outputs stay stable.
- Flush: takes priority over accept and emit in the same cycle. Clears main_valid and skid_valid and drops any incoming beat. id_instr=NOP_INSTR, id_se_select=000. if_ready=1 on the next cycle.
- Reset versus flush: reset dominates. Reset mid-transfer discards everything.
- Pre-decode: computed combinationally from if_instr[31:26] at capture and stored alongside the payload, so id_se_select is registered.
  - opcodes 0x08–0x0B (addi, addiu, slti, sltiu), 0x04–0x07 (branches), 0x20–0x2B (loads/stores) -> 000 (sign16).
  - 0x0C–0x0E (andi, ori, xori) -> 001 (zero16).
  - 0x0F (lui) -> 010.
  - R-type (0x00), jumps, and undefined opcodes -> 000.
  - Codes 011 and 100 (8-bit modes) are reserved for the load-data path and are never produced here.
- id_imm = stored instr[15:0], no arithmetic.

Decomposition:
- Shared package mips_pkg:
  - se_select_t enum: SE_SIGN16=3'b000, SE_ZERO16=3'b001, SE_LUI=3'b010, SE_SIGN8=3'b011, SE_ZERO8=3'b100.
  - Opcode localparams (OP_RTYPE, OP_ADDI … OP_LUI, OP_LW, OP_SW, …).
  - ifid_payload_t struct: instr, pc_plus4, se_select.
- Sub-module: se_select_decode (combinational, opcode -> se_select_t), reused later by the main control unit.

Test Plan:
- Reset: rst=1 for 2 cycles with if_valid=1 -> if_ready=0, id_valid=0, id_instr=0, id_se_select=000. After release, if_ready=1 on the first cycle.
- Streaming with id_ready=1: feed 0x3408FFFF (ori), 0x2008FFFF (addi), 0x3C011234 (lui) back-to-back -> emitted on cycles +1, +2, +3.
  - id_se_select = 001, 000, 010.
  - id_imm = FFFF, FFFF, 1234.
  - id_pc_plus4 matches each beat.
- Back-pressure: id_ready=0, present 3 beats -> beat 1 held at output, beat 2 in skid, if_ready=0 on the cycle after. Raise id_ready -> beats 1, 2, 3 emitted in order, none lost or duplicated.
- Flush with main and skid full and if_valid=1 in the same cycle -> next cycle id_valid=0, id_instr=NOP_INSTR, if_ready=1. The incoming beat never appears at the output.
- Decode corners: 0x00000020 (add) -> 000; opcode 0x3F -> 000; 0x8C220004 (lw) -> 000 with imm 0004. Codes 011 and 100 are never observed (assertion across random traffic).
- Random valid/ready/flush stimulus with a scoreboard model -> ordering, hold-stability and no-loss assertions pass for 10k cycles.
